key_debounce: RTL and testbench

//  Conditions one raw mechanical push-button so it can drive in_port of the Avalon PIO key slave.
//  - Synchronises the button into the clk domain.
//  - Rejects contact bounce shorter than DEBOUNCE_MS.
//  - Presents a clean active-high "pressed" level, plus single-cycle press/release pulses.
//  - Downstream edge capture therefore sees exactly one rising edge per physical press.

---
 rtl/key_debounce_pkg.sv | 19 +
 rtl/key_sync_2ff.sv | 24 ++
 rtl/key_debounce.sv | 163 ++++++++++++++++
 tb/tb_key_debounce.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/key_debounce_pkg.sv
// Shared types and helpers for the push-button conditioning blocks.
// The optional long-press timer is enabled with KEY_DEBOUNCE_LONGPRESS_EN.
package key_debounce_pkg;

  localparam int unsigned KB_STATE_W = 2;

  typedef enum logic [KB_STATE_W-1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } kb_state_t;

  // Milliseconds to clk cycles; divide first so large clocks do not overflow.
  function automatic int unsigned ms_to_cyc(input int unsigned clk_hz, input int unsigned ms);
    return (clk_hz / 32'd1000) * ms;
  endfunction

endpackage

// File: rtl/key_sync_2ff.sv
// Two-flop synchroniser for slow asynchronous inputs (keys, switches).
// Both flops reset to RST_VAL so the idle level is presented out of reset.
module key_sync_2ff #(
  parameter bit RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/key_debounce.sv
// Debounces one raw push-button into a clean pressed level plus press/release pulses.
// Define KEY_DEBOUNCE_LONGPRESS_EN to build the hold timer that drives key_long.
module key_debounce
  import key_debounce_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 50_000_000,
  parameter int unsigned DEBOUNCE_MS = 20,
  parameter int unsigned LONG_MS     = 1000,
  parameter bit          ACTIVE_LOW  = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic key_raw,
  output logic key_state,
  output logic key_press,
  output logic key_release,
  output logic key_long
);

  localparam int unsigned DB_CYC = ms_to_cyc(CLK_HZ, DEBOUNCE_MS);
  localparam int unsigned DB_W   = (DB_CYC < 1) ? 1 : $clog2(DB_CYC + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYC - 1);

  localparam logic [KB_STATE_W-1:0] S_IDLE         = IDLE;
  localparam logic [KB_STATE_W-1:0] S_PRESS_WAIT   = PRESS_WAIT;
  localparam logic [KB_STATE_W-1:0] S_PRESSED      = PRESSED;
  localparam logic [KB_STATE_W-1:0] S_RELEASE_WAIT = RELEASE_WAIT;

  if (DB_CYC == 0) begin : g_bad_db
    $error("key_debounce: debounce window of 0 cycles is not allowed");
  end

  logic                  sync_q;
  logic                  pin;
  logic [KB_STATE_W-1:0] state_q, state_d;
  logic [DB_W-1:0]       cnt_q, cnt_d;
  logic                  level_d, press_d, release_d;

  // Flops start at the released pin level so reset never looks like a press.
  key_sync_2ff #(
    .RST_VAL (ACTIVE_LOW)
  ) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (key_raw),
    .q       (sync_q)
  );

  assign pin = sync_q ^ ACTIVE_LOW;

  // Next state: a level change is accepted only after DB_CYC stable cycles.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    level_d   = key_state;
    press_d   = 1'b0;
    release_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pin) begin
          state_d = S_PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      S_PRESS_WAIT: begin
        if (!pin) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d = S_PRESSED;
          cnt_d   = '0;
          level_d = 1'b1;
          press_d = 1'b1;
        end else if (cnt_q < DB_LAST) begin
          cnt_d = cnt_q + DB_W'(1);
        end
      end
      S_PRESSED: begin
        if (!pin) begin
          state_d = S_RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      S_RELEASE_WAIT: begin
        if (pin) begin
          state_d = S_PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d   = S_IDLE;
          cnt_d     = '0;
          level_d   = 1'b0;
          release_d = 1'b1;
        end else if (cnt_q < DB_LAST) begin
          cnt_d = cnt_q + DB_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        level_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      key_state   <= 1'b0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      key_state   <= level_d;
      key_press   <= press_d;
      key_release <= release_d;
    end
  end

`ifdef KEY_DEBOUNCE_LONGPRESS_EN
  localparam int unsigned LONG_CYC = ms_to_cyc(CLK_HZ, LONG_MS);
  localparam int unsigned LONG_W   = (LONG_CYC < 1) ? 1 : $clog2(LONG_CYC + 1);
  localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CYC - 1);
  localparam logic [LONG_W-1:0] LONG_SAT  = LONG_W'(LONG_CYC);

  if (LONG_CYC == 0) begin : g_bad_long
    $error("key_debounce: long-press window of 0 cycles is not allowed");
  end

  logic [LONG_W-1:0] hold_q, hold_d;
  logic              hold_run;
  logic              long_d;

  // Hold time spans release bounce; it parks at LONG_CYC so the pulse fires once per press.
  always_comb begin
    hold_run = ((state_q == S_PRESSED) || (state_q == S_RELEASE_WAIT)) && (state_d != S_IDLE);
    hold_d   = '0;
    long_d   = 1'b0;
    if (hold_run) begin
      hold_d = (hold_q == LONG_SAT) ? hold_q : hold_q + LONG_W'(1);
      long_d = (hold_q == LONG_LAST);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_q   <= '0;
      key_long <= 1'b0;
    end else begin
      hold_q   <= hold_d;
      key_long <= long_d;
    end
  end
`else
  // LONG_MS only has meaning when the hold timer is built.
  if (LONG_MS == 0) begin : g_long_unused
  end

  assign key_long = 1'b0;
`endif

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with a 10-cycle debounce and 50-cycle long-press window.
module tb_key_debounce;

  localparam int unsigned DB_CYC   = 10;
  localparam int unsigned LONG_CYC = 50;
`ifdef KEY_DEBOUNCE_LONGPRESS_EN
  localparam bit LONG_EN = 1'b1;
`else
  localparam bit LONG_EN = 1'b0;
`endif

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  logic key_raw = 1'b1;
  logic key_state, key_press, key_release, key_long;

  int checks = 0;
  int errors = 0;
  int n_press, n_release, n_long;
  int first_press, first_release, first_long;
  logic prev_state;

  typedef struct {
    logic raw;
    int   cycles;
    logic exp_state;
    int   exp_press;
    int   exp_release;
    int   exp_long;
  } vec_t;

  vec_t vecs[$];

  key_debounce #(
    .CLK_HZ      (10_000),
    .DEBOUNCE_MS (1),
    .LONG_MS     (5),
    .ACTIVE_LOW  (1'b1)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .key_raw     (key_raw),
    .key_state   (key_state),
    .key_press   (key_press),
    .key_release (key_release),
    .key_long    (key_long)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Drive key_raw for n cycles, sampling 1 time unit after each rising edge.
  // Edge 1 is the first edge that samples the new key_raw value.
  task automatic run(input logic raw, input int n);
    key_raw       = raw;
    n_press       = 0;
    n_release     = 0;
    n_long        = 0;
    first_press   = -1;
    first_release = -1;
    first_long    = -1;
    prev_state    = key_state;
    for (int i = 1; i <= n; i++) begin
      @(posedge clk);
      #1;
      check("press_on_rise", int'(key_press), int'(key_state && !prev_state));
      check("release_on_fall", int'(key_release), int'(!key_state && prev_state));
      if (key_press) begin
        n_press++;
        if (first_press < 0) first_press = i;
      end
      if (key_release) begin
        n_release++;
        if (first_release < 0) first_release = i;
      end
      if (key_long) begin
        n_long++;
        if (first_long < 0) first_long = i;
      end
      prev_state = key_state;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_state"}, int'(key_state), 0);
    check({tag, "_press"}, int'(key_press), 0);
    check({tag, "_release"}, int'(key_release), 0);
    check({tag, "_long"}, int'(key_long), 0);
  endtask

  initial begin
    // raw, cycles, state at end, press/release/long pulses in the segment
    vecs.push_back('{1'b1, 100, 1'b0, 0, 0, 0});   // idle after reset
    vecs.push_back('{1'b0, 30,  1'b1, 1, 0, 0});   // clean press
    for (int k = 0; k < 5; k++) begin              // bounce while held
      vecs.push_back('{1'b1, 4, 1'b1, 0, 0, (k == 4) ? 1 : 0});
      vecs.push_back('{1'b0, 4, 1'b1, 0, 0, 0});
    end
    vecs.push_back('{1'b0, 20,  1'b1, 0, 0, 0});
    vecs.push_back('{1'b1, 9,   1'b1, 0, 0, 0});   // short release glitch
    vecs.push_back('{1'b0, 10,  1'b1, 0, 0, 0});
    vecs.push_back('{1'b1, 20,  1'b0, 0, 1, 0});   // real release
    vecs.push_back('{1'b0, DB_CYC, 1'b0, 0, 0, 0});   // longest rejected press glitch
    vecs.push_back('{1'b1, 15,  1'b0, 0, 0, 0});
    vecs.push_back('{1'b0, DB_CYC + 1, 1'b0, 0, 0, 0});  // shortest accepted press
    vecs.push_back('{1'b1, 40,  1'b0, 1, 1, 0});   // its pulse lands here, then release

    reset_n = 1'b0;
    key_raw = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("in_reset");
    reset_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      run(vecs[i].raw, vecs[i].cycles);
      check($sformatf("vec%0d_state", i), int'(key_state), int'(vecs[i].exp_state));
      check($sformatf("vec%0d_press", i), n_press, vecs[i].exp_press);
      check($sformatf("vec%0d_release", i), n_release, vecs[i].exp_release);
      check($sformatf("vec%0d_long", i), n_long, LONG_EN ? vecs[i].exp_long : 0);
    end

    // Exact latency: 2 sync edges plus DB_CYC stable cycles after edge 1; long press 50 later.
    run(1'b0, 100);
    check("lat_press_at", first_press, int'(DB_CYC) + 3);
    check("lat_press_cnt", n_press, 1);
    check("lat_state", int'(key_state), 1);
    check("long_cnt", n_long, LONG_EN ? 1 : 0);
    check("long_at", first_long, LONG_EN ? first_press + int'(LONG_CYC) : -1);
    run(1'b1, 30);
    check("lat_release_at", first_release, int'(DB_CYC) + 3);
    check("lat_release_cnt", n_release, 1);
    check("lat_long_after_release", n_long, 0);
    check("lat_idle_state", int'(key_state), 0);

    // Reset in the middle of a press count.
    run(1'b0, 6);
    #2;
    reset_n = 1'b0;
    #1;
    check_all_zero("rst_midcount");
    key_raw = 1'b1;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    run(1'b1, 50);
    check("rst_mid_press_cnt", n_press, 0);
    check("rst_mid_release_cnt", n_release, 0);
    check("rst_mid_state", int'(key_state), 0);

    // Reset while pressed must drop key_state without waiting for a clock.
    run(1'b0, 20);
    check("pre_rst_state", int'(key_state), 1);
    #2;
    reset_n = 1'b0;
    #1;
    check_all_zero("rst_pressed");
    key_raw = 1'b1;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    run(1'b1, 50);
    check("rst_press_cnt", n_press, 0);
    check("rst_release_cnt", n_release, 0);
    check("rst_long_cnt", n_long, 0);
    check("rst_state", int'(key_state), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
